piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/reg_pkg.sv | 25 ++
 rtl/piso_tx_bit_cnt.sv | 33 +++
 rtl/piso_tx.sv | 146 ++++++++++++++
 tb/tb_piso_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the piso_tx serializer: FSM state encoding,
// default payload width, serial idle level and the bit-counter width helper.
package reg_pkg;

    // Frame sequencing states; PARITY is only reachable when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Default payload width in bits.
    localparam int LEN_DEFAULT = 8;

    // Line level while no frame is in flight (also the stop-bit level).
    localparam logic SDO_IDLE = 1'b1;

    // Width of a counter that must hold LEN-1; never narrower than one bit.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_bit_cnt.sv
// bit_cnt: loadable down-counter used to count payload bits in SHIFT.
// Every update is qualified by the bit-rate tick; zero flags the last bit.
module bit_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] init,
    output logic         zero
);

    logic [W-1:0] count;

    // Load or decrement on bit-rate ticks; load wins over decrement.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            if (load) begin
                count <= init;
            end else if (dec) begin
                count <= count - W'(1);
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out frame transmitter.
// Frame: start bit (0), LEN payload bits LSB-first, optional even-parity bit,
// stop bit (1). Bit positions advance on clk_enable ticks; acceptance of a new
// payload happens on any clk edge while idle.
// Optional feature: define PISO_TX_PARITY_EN to insert the parity bit.
module piso_tx
    import reg_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           clk_enable,
    input  logic [LEN-1:0] data,
    input  logic           load,
    output logic           ready,
    output logic           sdo,
    output logic           busy,
    output logic           done
);

    localparam int            CW       = cnt_width(LEN);
    localparam logic [CW-1:0] CNT_INIT = CW'(LEN - 1);

    state_t         state;
    state_t         state_d;
    logic [LEN-1:0] shreg;
    logic [LEN-1:0] shreg_d;
    logic           sdo_d;
    logic           done_d;
    logic           cnt_zero;
    logic           cnt_load;
    logic           cnt_dec;

`ifdef PISO_TX_PARITY_EN
    logic           par_q;

    // Capture even parity of the payload at the moment it is accepted.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_q <= 1'b0;
        end else if ((state == IDLE) && load) begin
            par_q <= ^data;
        end
    end
`endif

    // Counter is armed with LEN-1 on the START tick and counts down through SHIFT.
    assign cnt_load = (state == START);
    assign cnt_dec  = (state == SHIFT) && !cnt_zero;

    bit_cnt #(
        .W(CW)
    ) u_bit_cnt (
        .clk  (clk),
        .clr  (clr),
        .en   (clk_enable),
        .load (cnt_load),
        .dec  (cnt_dec),
        .init (CNT_INIT),
        .zero (cnt_zero)
    );

    // Next-state, next shift-register contents and end-of-frame pulse.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    shreg_d = data;
                end
            end
            START: begin
                if (clk_enable) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (clk_enable) begin
                    shreg_d = shreg >> 1;
                    if (cnt_zero) begin
`ifdef PISO_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                if (clk_enable) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (clk_enable) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so the sdo flop tracks the FSM.
    always_comb begin
        sdo_d = SDO_IDLE;
        case (state_d)
            IDLE:    sdo_d = SDO_IDLE;
            START:   sdo_d = 1'b0;
            SHIFT:   sdo_d = shreg_d[0];
`ifdef PISO_TX_PARITY_EN
            PARITY:  sdo_d = par_q;
`endif
            STOP:    sdo_d = 1'b1;
            default: sdo_d = SDO_IDLE;
        endcase
    end

    // State, payload and registered outputs; clr aborts any frame in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            shreg <= '0;
            sdo   <= SDO_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            sdo   <= sdo_d;
            done  <= done_d;
        end
    end

    assign ready = (state == IDLE);
    assign busy  = !ready;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (LEN=8 and LEN=1 instances).
// Honours PISO_TX_PARITY_EN so the expected frames match the build.
module tb_piso_tx;
    import reg_pkg::*;

    localparam int LEN = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int NB  = LEN + 3;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = LEN + 2;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       clk_enable;
    logic       load;
    logic [7:0] data;
    logic       ready, sdo, busy, done;
    logic       load1;
    logic [0:0] data1;
    logic       ready1, sdo1, busy1, done1;

    int n_checks  = 0;
    int n_fail    = 0;
    int ce_period = 1;
    int ce_phase  = 0;
    logic ce_used;

    always #5 clk = ~clk;

    piso_tx #(.LEN(LEN)) u_dut (
        .clk        (clk),
        .clr        (clr),
        .clk_enable (clk_enable),
        .data       (data),
        .load       (load),
        .ready      (ready),
        .sdo        (sdo),
        .busy       (busy),
        .done       (done)
    );

    piso_tx #(.LEN(1)) u_dut1 (
        .clk        (clk),
        .clr        (clr),
        .clk_enable (clk_enable),
        .data       (data1),
        .load       (load1),
        .ready      (ready1),
        .sdo        (sdo1),
        .busy       (busy1),
        .done       (done1)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clk cycle; clk_enable is high on one edge in every ce_period.
    task automatic step(output logic used);
        clk_enable = (ce_phase == ce_period - 1);
        used       = clk_enable;
        ce_phase   = (ce_phase + 1) % ce_period;
        @(posedge clk);
        #1;
    endtask

    // Entered just after the accepting edge; walks the frame bit by bit.
    // load is held high for bit indices load_from..load_to with data=ldata.
    task automatic check_frame(input logic [7:0] d, input int load_from,
                               input int load_to, input logic [7:0] ldata,
                               input string tag);
        logic [NB-1:0] bits;
        logic          used;
        int            held;
        bits[0] = 1'b0;
        for (int i = 0; i < LEN; i++) bits[i+1] = d[i];
        if (PAR) bits[NB-2] = ^d;
        bits[NB-1] = 1'b1;
        for (int b = 0; b < NB; b++) begin
            held = 0;
            do begin
                check($sformatf("%s sdo b%0d", tag, b), sdo, bits[b]);
                check($sformatf("%s busy b%0d", tag, b), busy, 1'b1);
                check($sformatf("%s done b%0d", tag, b), done, 1'b0);
                load = (b >= load_from) && (b <= load_to);
                data = load ? ldata : ~d;
                step(used);
                held++;
            end while (!used && held < 16);
            if (b > 0) check_n($sformatf("%s hold b%0d", tag, b), held, ce_period);
            else       check($sformatf("%s start hold", tag), held <= ce_period, 1'b1);
        end
        check({tag, " done pulse"}, done, 1'b1);
        check({tag, " done ready"}, ready, 1'b1);
        check({tag, " done sdo"}, sdo, SDO_IDLE);
    endtask

    initial begin
        clr = 1'b1; clk_enable = 1'b0; load = 1'b0; data = 8'h00;
        load1 = 1'b0; data1 = 1'b0;
        #2;
        check("rst sdo", sdo, 1'b1);
        check("rst ready", ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst1 sdo", sdo1, 1'b1);
        check("rst1 ready", ready1, 1'b1);
        @(posedge clk); #1;
        clr = 1'b0;

        // Idle without load stays idle.
        step(ce_used); step(ce_used);
        check("idle ready", ready, 1'b1);
        check("idle sdo", sdo, 1'b1);
        check("idle busy", busy, 1'b0);

        // 8'hA5, continuous tick.
        load = 1'b1; data = 8'hA5;
        step(ce_used);
        check_frame(8'hA5, NB, NB, 8'h00, "a5");
        step(ce_used);
        check("a5 done once", done, 1'b0);
        check("a5 idle ready", ready, 1'b1);

        // 8'h07: parity 1 when enabled.
        load = 1'b1; data = 8'h07;
        step(ce_used);
        check_frame(8'h07, NB, NB, 8'h00, "h07");
        step(ce_used);
        check("h07 done once", done, 1'b0);

        // Tick 1 in 4, accepted off-tick, 8'hFF load mid-frame must be ignored.
        ce_period = 4; ce_phase = 0;
        load = 1'b1; data = 8'h3C;
        step(ce_used);
        check("3c accepted off-tick", busy, 1'b1);
        check_frame(8'h3C, 4, 6, 8'hFF, "3c");
        ce_period = 1; ce_phase = 0;
        step(ce_used);
        check("3c not queued ready", ready, 1'b1);
        check("3c not queued busy", busy, 1'b0);
        check("3c done once", done, 1'b0);

        // Back-to-back with load held high: 8'h01 then 8'h80.
        load = 1'b1; data = 8'h01;
        step(ce_used);
        check_frame(8'h01, 0, NB - 1, 8'h80, "b2b1");
        step(ce_used);
        check_frame(8'h80, 0, NB - 2, 8'h80, "b2b2");
        step(ce_used);
        check("b2b done once", done, 1'b0);
        check("b2b idle", ready, 1'b1);
        check("b2b idle sdo", sdo, 1'b1);

        // clr during the 4th data bit aborts with no done.
        load = 1'b1; data = 8'hA5;
        step(ce_used);
        load = 1'b0;
        for (int i = 0; i < 4; i++) step(ce_used);
        check("abort 4th bit", sdo, 1'b0);
        check("abort busy pre", busy, 1'b1);
        #2 clr = 1'b1;
        #1;
        check("abort sdo", sdo, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort ready", ready, 1'b1);
        check("abort done", done, 1'b0);
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(ce_used);
            check($sformatf("abort no done c%0d", i), done, 1'b0);
            check($sformatf("abort idle sdo c%0d", i), sdo, 1'b1);
        end
        load = 1'b1; data = 8'h55;
        step(ce_used);
        check_frame(8'h55, NB, NB, 8'h00, "h55");
        step(ce_used);
        check("h55 done once", done, 1'b0);

        // LEN=1: start, one data bit, optional parity, stop.
        load1 = 1'b1; data1 = 1'b0;
        step(ce_used);
        load1 = 1'b0; data1 = 1'b1;
        check("len1 start", sdo1, 1'b0);
        check("len1 busy", busy1, 1'b1);
        step(ce_used);
        check("len1 data", sdo1, 1'b0);
        step(ce_used);
        if (PAR) begin
            check("len1 parity", sdo1, 1'b0);
            step(ce_used);
        end
        check("len1 stop", sdo1, 1'b1);
        check("len1 stop done", done1, 1'b0);
        check("len1 stop busy", busy1, 1'b1);
        step(ce_used);
        check("len1 done", done1, 1'b1);
        check("len1 ready", ready1, 1'b1);
        step(ce_used);
        check("len1 done once", done1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
